// File: rtl/io_write_buffered_pkg.sv
// Shared definitions for the buffered I/O write stage: ready-state encoding,
// a constant-capable clog2, and the write-port address decode helpers.
package io_write_buffered_pkg;

  // Stage-1 ready encoding seen on EmptyFull_masked: EMPTY means the
  // addressed port still has room for another instruction, FULL means stall.
  localparam logic EMPTY = 1'b1;
  localparam logic FULL  = 1'b0;

  // Ceiling log2, usable in localparam expressions.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // True when addr falls inside the contiguous block of write ports that
  // starts at base and spans count ports.
  function automatic logic is_io(input int unsigned addr,
                                 input int unsigned base,
                                 input int unsigned count);
    return (addr >= base) && ((addr - base) < count);
  endfunction

  // Port number for an address already known to be inside the port block.
  function automatic int unsigned port_index(input int unsigned addr,
                                             input int unsigned base);
    return addr - base;
  endfunction

endpackage

// File: rtl/io_write_buffered_fifo.sv
// Single show-ahead FIFO for one I/O write port. The head word is presented
// whenever the FIFO holds data; a push arriving while full is dropped unless a
// pop frees the slot in the same cycle, and the drop latches a sticky error.
module io_write_fifo
  import io_write_buffered_pkg::*;
#(
  parameter  int WIDTH = 36,
  parameter  int DEPTH = 4,
  localparam int AW    = clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == CW'(DEPTH));
  assign valid   = (count != '0);
  assign do_pop  = pop & valid;
  // A pop in the same cycle makes room, so push-at-full with pop is legal.
  assign do_push = push & (~full | do_pop);
  // Empty FIFO presents zero rather than a stale word.
  assign head    = valid ? mem[rd_ptr] : '0;

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
      if (push & full & ~do_pop) overflow <= 1'b1;
    end
  end

  // Word storage; contents are don't-care until counted in.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/io_write_buffered.sv
// Buffered I/O write stage. Decodes ALU writes onto RAM and a block of output
// ports, queues port writes in per-port FIFOs drained by valid/ready, and
// raises the stage-1 stall from FIFO occupancy plus in-flight reservations.
module io_write_buffered
  import io_write_buffered_pkg::*;
#(
  parameter int WORD_WIDTH              = 36,
  parameter int ADDR_WIDTH              = 10,
  parameter int RAM_ADDR_WIDTH          = 10,
  parameter int IO_WRITE_PORT_COUNT     = 4,
  parameter int IO_WRITE_PORT_BASE_ADDR = 1020,
  parameter int FIFO_DEPTH              = 4,
  parameter int IN_FLIGHT_MAX           = 2
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [ADDR_WIDTH-1:0]                     addr_raw,
  input  logic                                      IO_ready,
  input  logic [WORD_WIDTH-1:0]                     ALU_result,
  input  logic [ADDR_WIDTH-1:0]                     ALU_addr,
  input  logic                                      ALU_write_is_IO,
  input  logic                                      ALU_wren,
  output logic                                      write_is_IO,
  output logic                                      EmptyFull_masked,
  output logic [IO_WRITE_PORT_COUNT-1:0]            port_valid,
  input  logic [IO_WRITE_PORT_COUNT-1:0]            port_ready,
  output logic [IO_WRITE_PORT_COUNT*WORD_WIDTH-1:0] port_data,
  output logic [IO_WRITE_PORT_COUNT-1:0]            port_overflow,
  output logic [WORD_WIDTH-1:0]                     data_RAM,
  output logic [RAM_ADDR_WIDTH-1:0]                 addr_RAM,
  output logic                                      wren_RAM
);

  localparam int CNT_W  = clog2(FIFO_DEPTH) + 1;
  localparam int PIDX_W = (IO_WRITE_PORT_COUNT > 1) ? clog2(IO_WRITE_PORT_COUNT) : 1;

  // Address decode for the stage-1 address and the ALU write address.
  logic              raw_io;
  logic [PIDX_W-1:0] raw_idx;
  logic              alu_io;
  logic [PIDX_W-1:0] alu_idx;

  assign raw_io  = is_io(32'(addr_raw), IO_WRITE_PORT_BASE_ADDR, IO_WRITE_PORT_COUNT);
  assign raw_idx = PIDX_W'(port_index(32'(addr_raw), IO_WRITE_PORT_BASE_ADDR));
  assign alu_io  = is_io(32'(ALU_addr), IO_WRITE_PORT_BASE_ADDR, IO_WRITE_PORT_COUNT);
  assign alu_idx = PIDX_W'(port_index(32'(ALU_addr), IO_WRITE_PORT_BASE_ADDR));

  // Per-port occupancy gathered from the FIFO instances.
  logic [CNT_W-1:0] fifo_count [IO_WRITE_PORT_COUNT];

  // Reservation delay line: one slot per pipeline stage between the stage-1
  // check and the FIFO push, each holding the port an accepted write targets.
  logic              pend_vld  [IN_FLIGHT_MAX];
  logic [PIDX_W-1:0] pend_port [IN_FLIGHT_MAX];
  logic              reserve;

  int               pending_raw;
  logic [CNT_W-1:0] count_raw;
  int               free_room;

  // Stage-1 check: the addressed port must keep IN_FLIGHT_MAX words of
  // headroom beyond what is stored and what is already promised to it.
  always_comb begin
    pending_raw = 0;
    count_raw   = '0;
    free_room   = FIFO_DEPTH;
    for (int i = 0; i < IN_FLIGHT_MAX; i++) begin
      if (pend_vld[i] && (pend_port[i] == raw_idx)) pending_raw = pending_raw + 1;
    end
    if (raw_io) count_raw = fifo_count[raw_idx];
    free_room = FIFO_DEPTH - int'(count_raw) - pending_raw;
    if (!raw_io)                       EmptyFull_masked = EMPTY;
    else if (free_room > IN_FLIGHT_MAX) EmptyFull_masked = EMPTY;
    else                               EmptyFull_masked = FULL;
  end

  // A stage-1 I/O write that passes the check while the thread is ready
  // claims a slot until it would have reached the FIFO.
  assign reserve = raw_io & (EmptyFull_masked == EMPTY) & IO_ready;

  // Shift reservations toward the FIFO; a reset forgets all of them.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < IN_FLIGHT_MAX; i++) pend_vld[i] <= 1'b0;
    end else begin
      pend_vld[0] <= reserve;
      for (int i = 1; i < IN_FLIGHT_MAX; i++) pend_vld[i] <= pend_vld[i-1];
    end
  end

  // Port tags travel with the valid bits and need no reset.
  always_ff @(posedge clock) begin
    pend_port[0] <= raw_idx;
    for (int i = 1; i < IN_FLIGHT_MAX; i++) pend_port[i] <= pend_port[i-1];
  end

  // I/O flag pipeline: decode registered, qualified by thread readiness,
  // then two more stages so it lines up with the instruction downstream.
  logic wio_p0;
  logic wio_p1;
  logic wio_p2;

  always_ff @(posedge clock) begin
    if (reset) begin
      wio_p0 <= 1'b0;
      wio_p1 <= 1'b0;
      wio_p2 <= 1'b0;
    end else begin
      wio_p0 <= raw_io;
      wio_p1 <= wio_p0 & IO_ready;
      wio_p2 <= wio_p1;
    end
  end

  assign write_is_IO = wio_p2;

  // RAM write port: ALU outputs registered once. The enable is not masked
  // for port addresses because the memory map leaves that range unused.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_RAM <= '0;
      addr_RAM <= '0;
      wren_RAM <= 1'b0;
    end else begin
      data_RAM <= ALU_result;
      addr_RAM <= ALU_addr[RAM_ADDR_WIDTH-1:0];
      wren_RAM <= ALU_wren;
    end
  end

  // Push register: the word lands in its FIFO on the edge that ends the
  // cycle in which wren_RAM is high for the same instruction.
  logic                  push_vld_p0;
  logic [PIDX_W-1:0]     push_idx_p0;
  logic [WORD_WIDTH-1:0] push_data_p0;

  always_ff @(posedge clock) begin
    if (reset) begin
      push_vld_p0 <= 1'b0;
    end else begin
      push_vld_p0 <= ALU_write_is_IO & ALU_wren & alu_io;
    end
  end

  // Push payload is qualified by push_vld_p0 and needs no reset.
  always_ff @(posedge clock) begin
    push_idx_p0  <= alu_idx;
    push_data_p0 <= ALU_result;
  end

  // One show-ahead FIFO per output port; at most one is pushed per cycle.
  for (genvar g = 0; g < IO_WRITE_PORT_COUNT; g++) begin : g_port
    logic                  fifo_push;
    logic                  fifo_valid;
    logic                  fifo_overflow;
    logic [WORD_WIDTH-1:0] fifo_head;
    logic [CNT_W-1:0]      fifo_cnt;

    assign fifo_push = push_vld_p0 && (push_idx_p0 == PIDX_W'(g));

    io_write_fifo #(
      .WIDTH (WORD_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (push_data_p0),
      .pop       (fifo_valid & port_ready[g]),
      .head      (fifo_head),
      .valid     (fifo_valid),
      .count     (fifo_cnt),
      .overflow  (fifo_overflow)
    );

    assign port_valid[g]                            = fifo_valid;
    assign port_overflow[g]                         = fifo_overflow;
    assign port_data[g*WORD_WIDTH +: WORD_WIDTH]    = fifo_head;
    assign fifo_count[g]                            = fifo_cnt;
  end

endmodule

// File: tb/tb_io_write_buffered.sv
// Bench for io_write_buffered: directed scenarios followed by random traffic,
// all checked cycle by cycle against a queue-level reference model.
module tb_io_write_buffered;

  localparam int WW    = 36;
  localparam int AW    = 10;
  localparam int RAW   = 10;
  localparam int NP    = 4;
  localparam int BASE  = 1020;
  localparam int DEPTH = 4;
  localparam int IFM   = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [AW-1:0]     addr_raw;
  logic              IO_ready;
  logic [WW-1:0]     ALU_result;
  logic [AW-1:0]     ALU_addr;
  logic              ALU_write_is_IO;
  logic              ALU_wren;
  logic              write_is_IO;
  logic              EmptyFull_masked;
  logic [NP-1:0]     port_valid;
  logic [NP-1:0]     port_ready;
  logic [NP*WW-1:0]  port_data;
  logic [NP-1:0]     port_overflow;
  logic [WW-1:0]     data_RAM;
  logic [RAW-1:0]    addr_RAM;
  logic              wren_RAM;

  always #5 clock = ~clock;

  io_write_buffered #(
    .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RAW),
    .IO_WRITE_PORT_COUNT(NP), .IO_WRITE_PORT_BASE_ADDR(BASE),
    .FIFO_DEPTH(DEPTH), .IN_FLIGHT_MAX(IFM)
  ) dut (
    .clock(clock), .reset(reset), .addr_raw(addr_raw), .IO_ready(IO_ready),
    .ALU_result(ALU_result), .ALU_addr(ALU_addr), .ALU_write_is_IO(ALU_write_is_IO),
    .ALU_wren(ALU_wren), .write_is_IO(write_is_IO), .EmptyFull_masked(EmptyFull_masked),
    .port_valid(port_valid), .port_ready(port_ready), .port_data(port_data),
    .port_overflow(port_overflow), .data_RAM(data_RAM), .addr_RAM(addr_RAM),
    .wren_RAM(wren_RAM)
  );

  int   errors = 0;
  int   checks = 0;
  bit   checking = 0;
  logic ef_seen;

  // Reference model: each port is a list of words with a size, plus overflow
  // flags, a history of the last IFM reservations, and the RAM/flag outputs.
  logic [WW-1:0]  mdat [NP][DEPTH];
  int             msz  [NP];
  bit             movf [NP];
  int             rh   [IFM];
  bit             mpush_v;
  int             mpush_p;
  logic [WW-1:0]  mpush_d;
  logic [WW-1:0]  m_ram_d;
  logic [RAW-1:0] m_ram_a;
  bit             m_ram_w;
  bit             rawq [3];
  bit             rdyq [3];
  bit             reserve;

  function automatic bit m_is_io(input logic [AW-1:0] a);
    return (int'(a) >= BASE) && (int'(a) < BASE + NP);
  endfunction

  function automatic bit m_ef(input logic [AW-1:0] a);
    int p;
    int pend;
    if (!m_is_io(a)) return 1'b1;
    p    = int'(a) - BASE;
    pend = 0;
    for (int i = 0; i < IFM; i++) if (rh[i] == p) pend++;
    return (DEPTH - msz[p] - pend) > IFM;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model across one rising edge using the inputs held there.
  task automatic model_edge();
    if (reset) begin
      for (int p = 0; p < NP; p++) begin msz[p] = 0; movf[p] = 0; end
      for (int i = 0; i < IFM; i++) rh[i] = -1;
      for (int i = 0; i < 3; i++) begin rawq[i] = 0; rdyq[i] = 0; end
      mpush_v = 0;
      m_ram_d = '0;
      m_ram_a = '0;
      m_ram_w = 0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (msz[p] > 0 && port_ready[p]) begin
          for (int i = 0; i < DEPTH - 1; i++) mdat[p][i] = mdat[p][i+1];
          msz[p]--;
        end
      end
      if (mpush_v) begin
        if (msz[mpush_p] < DEPTH) begin
          mdat[mpush_p][msz[mpush_p]] = mpush_d;
          msz[mpush_p]++;
        end else begin
          movf[mpush_p] = 1;
        end
      end
      for (int i = 0; i < IFM - 1; i++) rh[i] = rh[i+1];
      rh[IFM-1] = reserve ? (int'(addr_raw) - BASE) : -1;
      rawq[0] = rawq[1]; rawq[1] = rawq[2]; rawq[2] = m_is_io(addr_raw);
      rdyq[0] = rdyq[1]; rdyq[1] = rdyq[2]; rdyq[2] = IO_ready;
      mpush_v = ALU_write_is_IO && ALU_wren && m_is_io(ALU_addr);
      mpush_p = int'(ALU_addr) - BASE;
      mpush_d = ALU_result;
      m_ram_d = ALU_result;
      m_ram_a = ALU_addr[RAW-1:0];
      m_ram_w = ALU_wren;
    end
  endtask

  task automatic compare_all();
    logic [NP-1:0]    ev;
    logic [NP-1:0]    eo;
    logic [NP*WW-1:0] ed;
    for (int p = 0; p < NP; p++) begin
      ev[p] = (msz[p] > 0);
      eo[p] = movf[p];
      ed[p*WW +: WW] = (msz[p] > 0) ? mdat[p][0] : '0;
    end
    check("valid", port_valid, ev);
    check("data", port_data, ed);
    check("overflow", port_overflow, eo);
    check("ram_data", data_RAM, m_ram_d);
    check("ram_addr", addr_RAM, m_ram_a);
    check("ram_wren", wren_RAM, m_ram_w);
    check("write_is_io", write_is_IO, rawq[0] & rdyq[1]);
  endtask

  // One clock: stall check at the falling edge, state check after the rise.
  task automatic cycle();
    @(negedge clock);
    reserve = m_is_io(addr_raw) && m_ef(addr_raw) && IO_ready;
    ef_seen = EmptyFull_masked;
    if (checking) check("ef", EmptyFull_masked, m_ef(addr_raw));
    @(posedge clock);
    model_edge();
    #1;
    if (checking) compare_all();
  endtask

  task automatic drive(input bit rst, input logic [AW-1:0] raw, input bit rdy,
                       input logic [AW-1:0] addr, input logic [WW-1:0] data,
                       input bit io, input bit wr, input logic [NP-1:0] prdy);
    reset = rst; addr_raw = raw; IO_ready = rdy; ALU_addr = addr;
    ALU_result = data; ALU_write_is_IO = io; ALU_wren = wr; port_ready = prdy;
  endtask

  task automatic idle(input logic [AW-1:0] raw, input logic [NP-1:0] prdy);
    drive(0, raw, 1, '0, '0, 0, 0, prdy);
  endtask

  task automatic wr(input logic [AW-1:0] raw, input logic [AW-1:0] addr,
                    input logic [WW-1:0] data, input logic [NP-1:0] prdy);
    drive(0, raw, 1, addr, data, 1, 1, prdy);
  endtask

  initial begin
    // Reset state.
    drive(1, '0, 0, '0, '0, 0, 0, '0);
    cycle();
    checking = 1;
    cycle();
    check("rst_valid", port_valid, 0);
    check("rst_overflow", port_overflow, 0);
    check("rst_wren", wren_RAM, 0);
    check("rst_wio", write_is_IO, 0);

    // Single write to port 1.
    wr(0, 1021, 36'h123, 4'b0000); cycle();
    check("t1_wren_on", wren_RAM, 1);
    check("t1_valid_early", port_valid, 0);
    idle(0, 4'b0000); cycle();
    check("t1_valid", port_valid, 4'b0010);
    check("t1_data1", port_data[WW +: WW], 36'h123);
    check("t1_wren_off", wren_RAM, 0);
    idle(0, 4'b0010); cycle();
    check("t1_drained", port_valid, 0);

    // Stall threshold on port 0 with the consumer stopped.
    wr(1020, 1020, 36'hA0, 4'b0000); cycle();
    check("t2_ef_first", ef_seen, 1);
    wr(1020, 1020, 36'hA1, 4'b0000); cycle();
    check("t2_ef_second", ef_seen, 1);
    idle(1020, 4'b0000); cycle();
    check("t2_ef_drop", ef_seen, 0);
    for (int i = 0; i < 3; i++) cycle();
    check("t2_ef_held", ef_seen, 0);
    check("t2_no_overflow", port_overflow, 0);
    idle(0, 4'b0001); cycle(); cycle(); cycle();
    check("t2_drained", port_valid, 0);

    // Push and pop together on a full port 2.
    wr(0, 1022, 36'hA, 4'b0000); cycle();
    wr(0, 1022, 36'hB, 4'b0000); cycle();
    wr(0, 1022, 36'hC, 4'b0000); cycle();
    wr(0, 1022, 36'hD, 4'b0000); cycle();
    idle(0, 4'b0000); cycle();
    wr(0, 1022, 36'hE, 4'b0000); cycle();
    idle(0, 4'b0100); cycle();
    check("t3_head_b", port_data[2*WW +: WW], 36'hB);
    check("t3_no_overflow", port_overflow, 0);
    cycle(); check("t3_head_c", port_data[2*WW +: WW], 36'hC);
    cycle(); check("t3_head_d", port_data[2*WW +: WW], 36'hD);
    cycle(); check("t3_head_e", port_data[2*WW +: WW], 36'hE);
    cycle(); check("t3_empty", port_valid, 0);

    // Overflow on port 3, sticky until reset.
    for (int i = 0; i < 5; i++) begin
      wr(0, 1023, 36'h300 + WW'(i), 4'b0000); cycle();
    end
    idle(0, 4'b0000); cycle();
    check("t4_overflow", port_overflow, 4'b1000);
    check("t4_head_kept", port_data[3*WW +: WW], 36'h300);
    idle(0, 4'b1000); cycle();
    idle(0, 4'b0000); cycle();
    check("t4_sticky", port_overflow[3], 1);
    drive(1, '0, 0, '0, '0, 0, 0, '0); cycle();
    check("t4_rst_overflow", port_overflow, 0);
    check("t4_rst_valid", port_valid, 0);

    // RAM address with full port 0, then stage-1 I/O flag latency.
    for (int i = 0; i < 4; i++) begin
      wr(5, 1020, 36'h400 + WW'(i), 4'b0000); cycle();
    end
    idle(5, 4'b0000); cycle(); cycle(); cycle();
    check("t5_ef_ram_addr", ef_seen, 1);
    check("t5_wio_ram", write_is_IO, 0);
    idle(1020, 4'b0000); cycle();
    check("t5_ef_full", ef_seen, 0);
    cycle();
    check("t5_wio_latency", write_is_IO, 0);
    cycle();
    check("t5_wio_set", write_is_IO, 1);
    idle(0, 4'b1111); for (int i = 0; i < 4; i++) cycle();

    // Reset with writes in flight and port 1 holding three words.
    for (int i = 0; i < 3; i++) begin
      wr(0, 1021, 36'h500 + WW'(i), 4'b0000); cycle();
    end
    idle(0, 4'b0000); cycle();
    wr(1021, 1022, 36'h77, 4'b0000); cycle();
    drive(1, 1021, 1, 1022, 36'h88, 1, 1, 4'b0000); cycle();
    check("t6_valid", port_valid, 0);
    check("t6_ram_data", data_RAM, 0);
    check("t6_ram_addr", addr_RAM, 0);
    check("t6_ram_wren", wren_RAM, 0);
    idle(0, 4'b0000); cycle();
    check("t6_no_push", port_valid, 0);

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      logic [AW-1:0]  r_raw;
      logic [AW-1:0]  r_addr;
      logic [NP-1:0]  r_rdy;
      r_raw  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'(1018 + $urandom_range(0, 5));
      r_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'(1018 + $urandom_range(0, 5));
      r_rdy  = NP'($urandom) & NP'($urandom);
      drive($urandom_range(0, 63) == 0, r_raw, $urandom_range(0, 3) != 0, r_addr,
            {4'($urandom), 32'($urandom)}, $urandom_range(0, 7) != 0,
            $urandom_range(0, 3) != 0, r_rdy);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
